// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and a 32-bit ALU: decodes one op, drives ALU from registers, returns result.
// Optional macro ALU_OVF_EN adds the res_ovf signed-overflow output.
module alu_issue_ctrl #(
    parameter int unsigned ALU_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [15:0] in_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_fun,
    input  logic [31:0] alu_out,
    input  logic        alu_z,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_zero,
    output logic        res_taken,
    output logic        res_illegal
`ifdef ALU_OVF_EN
    ,
    output logic        res_ovf
`endif
);

    localparam logic [2:0] FUN_AND = 3'b000;
    localparam logic [2:0] FUN_OR  = 3'b001;
    localparam logic [2:0] FUN_ADD = 3'b010;
    localparam logic [2:0] FUN_SUB = 3'b110;
    localparam logic [2:0] FUN_SLT = 3'b111;
    localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t      state_r, state_s;
    logic [3:0]  wait_cnt_r;
    logic        beq_r, bne_r;
    logic        in_ready_r, res_valid_r;
    logic [31:0] alu_a_r, alu_b_r, res_data_r;
    logic [2:0]  alu_fun_r;
    logic        res_zero_r, res_taken_r, res_illegal_r;
    logic        dec_legal_s, dec_beq_s, dec_bne_s;
    logic [2:0]  dec_fun_s;
    logic [31:0] dec_b_s;

`ifdef ALU_OVF_EN
    logic res_ovf_r;

    // Two's-complement overflow of the operation the ALU just performed.
    function automatic logic ovf_f(input logic [2:0] fun, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] y);
        logic ovf;
        case (fun)
            FUN_ADD: ovf = (a[31] == b[31]) && (y[31] != a[31]);
            FUN_SUB: ovf = (a[31] != b[31]) && (y[31] != a[31]);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction
`endif

    // Decode opcode/funct into ALU function code, B operand and branch kind.
    always_comb begin
        dec_legal_s = 1'b1;
        dec_fun_s   = FUN_AND;
        dec_b_s     = in_b;
        dec_beq_s   = 1'b0;
        dec_bne_s   = 1'b0;
        case (in_op)
            6'h00: begin
                case (in_funct)
                    6'h20:   dec_fun_s = FUN_ADD;
                    6'h22:   dec_fun_s = FUN_SUB;
                    6'h24:   dec_fun_s = FUN_AND;
                    6'h25:   dec_fun_s = FUN_OR;
                    6'h2A:   dec_fun_s = FUN_SLT;
                    default: dec_legal_s = 1'b0;
                endcase
            end
            6'h08: begin dec_fun_s = FUN_ADD; dec_b_s = {{16{in_imm[15]}}, in_imm}; end
            6'h0A: begin dec_fun_s = FUN_SLT; dec_b_s = {{16{in_imm[15]}}, in_imm}; end
            6'h0C: begin dec_fun_s = FUN_AND; dec_b_s = {16'h0000, in_imm}; end
            6'h0D: begin dec_fun_s = FUN_OR;  dec_b_s = {16'h0000, in_imm}; end
            6'h04: begin dec_fun_s = FUN_SUB; dec_beq_s = 1'b1; end
            6'h05: begin dec_fun_s = FUN_SUB; dec_bne_s = 1'b1; end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // Next-state logic; illegal requests skip ISSUE and report straight away.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = dec_legal_s ? ISSUE : RESP;
                else          state_s = IDLE;
            end
            ISSUE: begin
                if (wait_cnt_r == 4'd0) state_s = RESP;
                else                    state_s = ISSUE;
            end
            RESP: begin
                if (res_ready) state_s = IDLE;
                else           state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            res_valid_r <= (state_s == RESP);
        end
    end

    // Operand launch, wait countdown and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r       <= 32'h0000_0000;
            alu_b_r       <= 32'h0000_0000;
            alu_fun_r     <= 3'b000;
            wait_cnt_r    <= 4'd0;
            beq_r         <= 1'b0;
            bne_r         <= 1'b0;
            res_data_r    <= 32'h0000_0000;
            res_zero_r    <= 1'b0;
            res_taken_r   <= 1'b0;
            res_illegal_r <= 1'b0;
`ifdef ALU_OVF_EN
            res_ovf_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && dec_legal_s) begin
                        alu_a_r    <= in_a;
                        alu_b_r    <= dec_b_s;
                        alu_fun_r  <= dec_fun_s;
                        wait_cnt_r <= WAIT_INIT;
                        beq_r      <= dec_beq_s;
                        bne_r      <= dec_bne_s;
                    end else if (in_valid) begin
                        res_data_r    <= 32'h0000_0000;
                        res_zero_r    <= 1'b0;
                        res_taken_r   <= 1'b0;
                        res_illegal_r <= 1'b1;
`ifdef ALU_OVF_EN
                        res_ovf_r     <= 1'b0;
`endif
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                ISSUE: begin
                    if (wait_cnt_r != 4'd0) begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end else begin
                        res_data_r    <= alu_out;
                        res_zero_r    <= alu_z;
                        res_taken_r   <= (beq_r & alu_z) | (bne_r & ~alu_z);
                        res_illegal_r <= 1'b0;
`ifdef ALU_OVF_EN
                        res_ovf_r     <= ovf_f(alu_fun_r, alu_a_r, alu_b_r, alu_out);
`endif
                    end
                end
                default: wait_cnt_r <= wait_cnt_r;
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign res_valid   = res_valid_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_fun     = alu_fun_r;
    assign res_data    = res_data_r;
    assign res_zero    = res_zero_r;
    assign res_taken   = res_taken_r;
    assign res_illegal = res_illegal_r;
`ifdef ALU_OVF_EN
    assign res_ovf     = res_ovf_r;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: two instances (ALU_WAIT=0 and ALU_WAIT=3), each with a behavioural ALU.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [31:0] d;
        logic        z;
        logic        t;
        logic        il;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic        rst0, iv0, ir0, az0, rv0, rr0, rz0, rt0, ri0;
    logic [5:0]  op0, fn0;
    logic [15:0] imm0;
    logic [31:0] a0, b0, aa0, ab0, ao0, rd0;
    logic [2:0]  af0;
    logic        rst1, iv1, ir1, az1, rv1, rr1, rz1, rt1, ri1;
    logic [5:0]  op1, fn1;
    logic [15:0] imm1;
    logic [31:0] a1, b1, aa1, ab1, ao1, rd1;
    logic [2:0]  af1;
`ifdef ALU_OVF_EN
    logic ro0, ro1;
`endif

    function automatic logic [31:0] alu_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign ao0 = alu_m(af0, aa0, ab0);
    assign az0 = af0[1] & (ao0 == 32'd0);
    assign ao1 = alu_m(af1, aa1, ab1);
    assign az1 = af1[1] & (ao1 == 32'd0);

    alu_issue_ctrl #(.ALU_WAIT(0)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .in_op(op0), .in_funct(fn0),
        .in_a(a0), .in_b(b0), .in_imm(imm0), .alu_a(aa0), .alu_b(ab0), .alu_fun(af0),
        .alu_out(ao0), .alu_z(az0), .res_valid(rv0), .res_ready(rr0), .res_data(rd0),
        .res_zero(rz0), .res_taken(rt0), .res_illegal(ri0)
`ifdef ALU_OVF_EN
        , .res_ovf(ro0)
`endif
    );

    alu_issue_ctrl #(.ALU_WAIT(3)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .in_op(op1), .in_funct(fn1),
        .in_a(a1), .in_b(b1), .in_imm(imm1), .alu_a(aa1), .alu_b(ab1), .alu_fun(af1),
        .alu_out(ao1), .alu_z(az1), .res_valid(rv1), .res_ready(rr1), .res_data(rd1),
        .res_zero(rz1), .res_taken(rt1), .res_illegal(ri1)
`ifdef ALU_OVF_EN
        , .res_ovf(ro1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor for instance 0: compare at every result handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst0 && rv0 && rr0) begin
            if (q0.size() == 0) begin
                chk("d0_unexpected_result", 32'(rv0), 32'd0);
            end else begin
                e = q0.pop_front();
                chk("d0_res_data", rd0, e.d);
                chk("d0_res_zero", 32'(rz0), 32'(e.z));
                chk("d0_res_taken", 32'(rt0), 32'(e.t));
                chk("d0_res_illegal", 32'(ri0), 32'(e.il));
`ifdef ALU_OVF_EN
                chk("d0_res_ovf", 32'(ro0), 32'(e.ov));
`endif
            end
        end
    end

    // Monitor for instance 1
    always @(negedge clk) begin
        exp_t e;
        if (!rst1 && rv1 && rr1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_result", 32'(rv1), 32'd0);
            end else begin
                e = q1.pop_front();
                chk("d1_res_data", rd1, e.d);
                chk("d1_res_zero", 32'(rz1), 32'(e.z));
                chk("d1_res_taken", 32'(rt1), 32'(e.t));
                chk("d1_res_illegal", 32'(ri1), 32'(e.il));
`ifdef ALU_OVF_EN
                chk("d1_res_ovf", 32'(ro1), 32'(e.ov));
`endif
            end
        end
    end

    task automatic wait_ready0();
        for (int i = 0; i < 50; i++) begin
            if (ir0) break;
            @(posedge clk); #1;
        end
        if (!ir0) chk("d0_in_ready_timeout", 32'(ir0), 32'd1);
    endtask

    task automatic wait_ready1();
        for (int i = 0; i < 50; i++) begin
            if (ir1) break;
            @(posedge clk); #1;
        end
        if (!ir1) chk("d1_in_ready_timeout", 32'(ir1), 32'd1);
    endtask

    // Legal op on instance 0: check launch, one-cycle latency, then let the monitor compare.
    task automatic send0(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm, input logic [2:0] efun,
                         input logic [31:0] eb, input logic [31:0] ed, input logic ez,
                         input logic et, input logic eo);
        wait_ready0();
        op0 = op; fn0 = fn; a0 = a; b0 = b; imm0 = imm; iv0 = 1'b1;
        q0.push_back({ed, ez, et, 1'b0, eo});
        @(posedge clk); #1;
        iv0 = 1'b0;
        chk("d0_alu_fun", 32'(af0), 32'(efun));
        chk("d0_alu_a", aa0, a);
        chk("d0_alu_b", ab0, eb);
        chk("d0_valid_not_yet", 32'(rv0), 32'd0);
        @(posedge clk); #1;
        chk("d0_valid_latency", 32'(rv0), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; iv0 = 1'b0; iv1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
        op0 = 6'd0; fn0 = 6'd0; a0 = 32'd0; b0 = 32'd0; imm0 = 16'd0;
        op1 = 6'd0; fn1 = 6'd0; a1 = 32'd0; b1 = 32'd0; imm1 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_a", aa0, 32'd0);
        chk("rst_alu_b", ab0, 32'd0);
        chk("rst_alu_fun", 32'(af0), 32'd0);
        chk("rst_res_valid", 32'(rv0), 32'd0);
        chk("rst_res_flags", {28'd0, rz0, rt0, ri0, 1'b0}, 32'd0);
        chk("rst_res_data", rd0, 32'd0);
        chk("rst_in_ready", 32'(ir0), 32'd1);
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        // op, funct, a, b, imm, fun, alu_b, data, z, taken, ovf
        send0(6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 3'b010, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
        send0(6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0000, 3'b110, 32'h1234, 32'd0, 1'b1, 1'b1, 1'b0);
        send0(6'h05, 6'h00, 32'h1234, 32'h1234, 16'h0000, 3'b110, 32'h1234, 32'd0, 1'b1, 1'b0, 1'b0);
        send0(6'h05, 6'h00, 32'd3, 32'd9, 16'h0000, 3'b110, 32'd9, 32'hFFFF_FFFA, 1'b0, 1'b1, 1'b0);
        send0(6'h0C, 6'h00, 32'hFFFF_FFFF, 32'd0, 16'h8001, 3'b000, 32'h0000_8001, 32'h0000_8001, 1'b0, 1'b0, 1'b0);
        send0(6'h0A, 6'h00, 32'hFFFF_FFFE, 32'd0, 16'hFFFF, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
        send0(6'h00, 6'h22, 32'd10, 32'd10, 16'h0000, 3'b110, 32'd10, 32'd0, 1'b1, 1'b0, 1'b0);
        send0(6'h00, 6'h20, 32'hFFFF_FFFF, 32'd1, 16'h0000, 3'b010, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        send0(6'h00, 6'h2A, 32'd4, 32'd4, 16'h0000, 3'b111, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0);
        send0(6'h00, 6'h25, 32'd0, 32'd0, 16'h0000, 3'b001, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        send0(6'h08, 6'h00, 32'd1, 32'd0, 16'hFFFF, 3'b010, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_OVF_EN
        send0(6'h00, 6'h20, 32'h7FFF_FFFF, 32'd1, 16'h0000, 3'b010, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        send0(6'h00, 6'h22, 32'h8000_0000, 32'd1, 16'h0000, 3'b110, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        send0(6'h00, 6'h25, 32'h8000_0000, 32'd1, 16'h0000, 3'b001, 32'd1, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
`endif
        send0(6'h0D, 6'h00, 32'd0, 32'd0, 16'h8000, 3'b001, 32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 1'b0);

        // Illegal opcode while the consumer stalls; a competing request must be ignored
        wait_ready0();
        rr0 = 1'b0; op0 = 6'h3F; iv0 = 1'b1;
        q0.push_back({32'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        op0 = 6'h00; fn0 = 6'h20; a0 = 32'hDEAD; b0 = 32'd1;
        chk("ill_valid", 32'(rv0), 32'd1);
        chk("ill_alu_a_kept", aa0, 32'd0);
        chk("ill_alu_b_kept", ab0, 32'h0000_8000);
        chk("ill_alu_fun_kept", 32'(af0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(rv0), 32'd1);
            chk("stall_data", rd0, 32'd0);
            chk("stall_illegal", 32'(ri0), 32'd1);
            chk("stall_in_ready", 32'(ir0), 32'd0);
        end
        rr0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        chk("post_hs_in_ready", 32'(ir0), 32'd1);
        chk("post_hs_alu_a", aa0, 32'd0);
        @(posedge clk); #1;
        chk("post_hs_no_valid", 32'(rv0), 32'd0);

        // Illegal funct under op 0
        op0 = 6'h00; fn0 = 6'h21; iv0 = 1'b1;
        q0.push_back({32'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        iv0 = 1'b0;
        chk("ill_funct_valid", 32'(rv0), 32'd1);
        @(posedge clk); #1;

        // ALU_WAIT=3: operands held four cycles, result at accept+4
        wait_ready1();
        op1 = 6'h00; fn1 = 6'h20; a1 = 32'd3; b1 = 32'd4; iv1 = 1'b1;
        q1.push_back({32'd7, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        iv1 = 1'b0;
        chk("w3_alu_fun", 32'(af1), 32'b010);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("w3_not_valid", 32'(rv1), 32'd0);
            chk("w3_alu_a_hold", aa1, 32'd3);
            chk("w3_alu_b_hold", ab1, 32'd4);
        end
        @(posedge clk); #1;
        chk("w3_valid_at_4", 32'(rv1), 32'd1);
        @(posedge clk); #1;

        // Reset in the second ISSUE cycle discards the operation
        wait_ready1();
        op1 = 6'h00; fn1 = 6'h20; a1 = 32'd9; b1 = 32'd1; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_alu_a", aa1, 32'd0);
        chk("mid_rst_alu_b", ab1, 32'd0);
        chk("mid_rst_alu_fun", 32'(af1), 32'd0);
        chk("mid_rst_res", {rd1[30:0] | 31'd0, rv1} | {28'd0, rz1, rt1, ri1, 1'b0}, 32'd0);
        chk("mid_rst_in_ready", 32'(ir1), 32'd1);
        rst1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_result", 32'(rv1), 32'd0);
        end

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
